// File: rtl/print_pkg.sv
// Shared types and constants for the count= line parser.
// Holds FSM/error enums, ASCII constants and the prefix.
package print_pkg;

  typedef enum logic [1:0] {
    ST_MATCH,
    ST_DIGITS,
    ST_EMIT,
    ST_RESYNC
  } parse_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PREFIX   = 2'd1,
    ERR_CHAR     = 2'd2,
    ERR_OVERFLOW = 2'd3
  } parse_err_t;

  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  localparam int COUNT_PREFIX_LEN = 6;

  localparam logic [0:COUNT_PREFIX_LEN-1][7:0]
    COUNT_PREFIX = "count=";

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= ASCII_0) && (b <= ASCII_0 + 8'd9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator: acc = acc*10 + digit with a
// look-ahead overflow flag for the digit presented now.
module dec_accum #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] val,
  output logic             has_digit,
  output logic             ovf
);

  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 2);

  localparam logic [AW-1:0] MAX_VAL =
    {4'b0000, {WIDTH{1'b1}}};

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [CW-1:0] cnt;

  // Candidate value if the presented digit is taken.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1)
             + {{WIDTH{1'b0}}, digit};
    ovf = (acc_next > MAX_VAL)
       || (cnt == CW'(MAX_DIGITS));
  end

  // Accumulator and digit counter; overflowing digits
  // are never folded in so acc always stays in range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (load && !ovf) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
    end
  end

  assign val       = acc[WIDTH-1:0];
  assign has_digit = (cnt != '0);

endmodule

// File: rtl/count_line_parser.sv
// Parses "count=<decimal>\n" lines into binary values.
// Malformed lines pulse err and resync on newline.
module count_line_parser
  import print_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             err,
  output logic [1:0]       err_code
);

  parse_state_t     state, state_d;
  logic [2:0]       idx, idx_d;
  logic             err_d;
  parse_err_t       code_d, code_q;
  logic [WIDTH-1:0] data_d;

  logic             accept;
  logic             nl;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] acc_val;
  logic             has_digit;
  logic             ovf;

  assign in_ready = (state != ST_EMIT);
  assign accept   = in_valid && in_ready;
  assign nl       = (in_data == ASCII_NL);
  assign err_code = code_q;

  dec_accum #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .load      (load),
    .digit     (in_data[3:0]),
    .val       (acc_val),
    .has_digit (has_digit),
    .ovf       (ovf)
  );

  // Next-state, error and output decode.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    data_d  = out_data;
    clr     = 1'b0;
    load    = 1'b0;
    unique case (state)
      ST_MATCH: begin
        if (accept) begin
          if (in_data == COUNT_PREFIX[idx]) begin
            if (idx == 3'(COUNT_PREFIX_LEN - 1)) begin
              state_d = ST_DIGITS;
              idx_d   = '0;
              clr     = 1'b1;
            end else begin
              idx_d = idx + 3'd1;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_PREFIX;
            idx_d   = '0;
            state_d = nl ? ST_MATCH : ST_RESYNC;
          end
        end
      end
      ST_DIGITS: begin
        if (accept) begin
          if (is_digit(in_data)) begin
            if (ovf) begin
              err_d   = 1'b1;
              code_d  = ERR_OVERFLOW;
              state_d = ST_RESYNC;
            end else begin
              load = 1'b1;
            end
          end else if (nl) begin
            if (has_digit) begin
              data_d  = acc_val;
              state_d = ST_EMIT;
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_CHAR;
              state_d = ST_MATCH;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHAR;
            state_d = ST_RESYNC;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_MATCH;
          idx_d   = '0;
        end
      end
      ST_RESYNC: begin
        if (accept && nl) begin
          state_d = ST_MATCH;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_MATCH;
        idx_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_MATCH;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      out_valid <= (state_d == ST_EMIT);
      out_data  <= data_d;
      err       <= err_d;
      code_q    <= code_d;
    end
  end

endmodule

// File: tb/tb_count_line_parser.sv
// Directed bench for count_line_parser.
// Each task drives one scenario and checks inline.
module tb_count_line_parser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;

  int passed = 0;
  int total  = 0;

  int nbytes = 0;
  int n_err  = 0;
  int err_at = 0;
  int n_out  = 0;
  int last_out = -1;
  int val_at = 0;
  int n_vcyc = 0;
  int n_both = 0;
  logic [1:0] last_code = 2'd0;
  logic prev_valid = 1'b0;

  count_line_parser #(
    .WIDTH      (8),
    .MAX_DIGITS (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Count accepted bytes at the active edge.
  always @(posedge clk)
    if (in_valid && in_ready) nbytes++;

  // Record output events mid-cycle.
  always @(negedge clk) begin
    if (err) begin
      n_err++;
      err_at = nbytes;
      last_code = err_code;
    end
    if (out_valid) begin
      n_vcyc++;
      if (!prev_valid) val_at = nbytes;
    end
    if (out_valid && out_ready) begin
      n_out++;
      last_out = int'(out_data);
    end
    if (err && out_valid) n_both++;
    prev_valid = out_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      idle(1);
      guard++;
    end
    total++;
    if (!in_ready)
      $display("FAIL in_ready_timeout byte %h", b);
    else
      passed++;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  task automatic chk(input string nm,
                     input int got, input int exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got %0d expected %0d",
               nm, got, exp);
    else
      passed++;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    idle(2);
    total++;
    if ({out_valid, out_data, err, err_code, in_ready}
        !== {1'b0, 8'd0, 1'b0, 2'd0, 1'b1})
      $display("FAIL reset_outputs got %b%h%b%h%b",
               out_valid, out_data, err, err_code,
               in_ready);
    else
      passed++;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    int b_bytes = nbytes;
    int b_out = n_out;
    int b_err = n_err;
    int b_vc  = n_vcyc;
    send_line("count=42");
    send_byte(8'h0A);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd42)
      $display("FAIL basic_latency got v=%b d=%0d exp v=1 d=42",
               out_valid, out_data);
    else
      passed++;
    idle(3);
    chk("basic_nout", n_out - b_out, 1);
    chk("basic_data", last_out, 42);
    chk("basic_val_at", val_at - b_bytes, 9);
    chk("basic_vcycles", n_vcyc - b_vc, 1);
    chk("basic_noerr", n_err - b_err, 0);
  endtask

  task automatic test_overflow;
    int b_bytes;
    int b_out;
    int b_err;
    send_line("count=255\n");
    idle(3);
    chk("max_data", last_out, 255);
    b_bytes = nbytes;
    b_out = n_out;
    b_err = n_err;
    send_line("count=256\n");
    idle(3);
    chk("ovf_nerr", n_err - b_err, 1);
    chk("ovf_code", int'(last_code), 3);
    chk("ovf_at", err_at - b_bytes, 9);
    chk("ovf_noout", n_out - b_out, 0);
  endtask

  task automatic test_prefix;
    int b_bytes = nbytes;
    int b_out;
    int b_err = n_err;
    send_line("cnt=5\n");
    idle(2);
    chk("pfx_nerr", n_err - b_err, 1);
    chk("pfx_code", int'(last_code), 1);
    chk("pfx_at", err_at - b_bytes, 2);
    b_out = n_out;
    send_line("count=7\n");
    idle(3);
    chk("pfx_recover_n", n_out - b_out, 1);
    chk("pfx_recover_d", last_out, 7);
    b_bytes = nbytes;
    b_err = n_err;
    send_line("count=\n");
    idle(2);
    chk("empty_nerr", n_err - b_err, 1);
    chk("empty_code", int'(last_code), 2);
    chk("empty_at", err_at - b_bytes, 7);
    b_out = n_out;
    send_line("count=0\n");
    idle(3);
    chk("zero_n", n_out - b_out, 1);
    chk("zero_d", last_out, 0);
  endtask

  task automatic test_cr_and_nl_prefix;
    int b_bytes = nbytes;
    int b_out = n_out;
    int b_err = n_err;
    send_line("count=5\r\n");
    idle(2);
    chk("cr_code", int'(last_code), 2);
    chk("cr_at", err_at - b_bytes, 8);
    chk("cr_noout", n_out - b_out, 0);
    b_bytes = nbytes;
    b_err = n_err;
    send_line("count\ncount=4\n");
    idle(3);
    chk("nlpfx_nerr", n_err - b_err, 1);
    chk("nlpfx_code", int'(last_code), 1);
    chk("nlpfx_at", err_at - b_bytes, 6);
    chk("nlpfx_next", last_out, 4);
  endtask

  task automatic test_backpressure;
    int b_vc;
    int b_out;
    out_ready = 1'b0;
    b_vc = n_vcyc;
    b_out = n_out;
    send_line("count=9\n");
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out_data, in_ready}
          !== {1'b1, 8'd9, 1'b0})
        $display("FAIL bp_hold%0d got v=%b d=%0d r=%b",
                 i, out_valid, out_data, in_ready);
      else
        passed++;
      idle(1);
    end
    out_ready = 1'b1;
    total++;
    if ({out_valid, out_data, in_ready}
        !== {1'b1, 8'd9, 1'b0})
      $display("FAIL bp_last got v=%b d=%0d r=%b",
               out_valid, out_data, in_ready);
    else
      passed++;
    idle(1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got v=%b r=%b exp v=0 r=1",
               out_valid, in_ready);
    else
      passed++;
    chk("bp_vcycles", n_vcyc - b_vc, 4);
    chk("bp_nout", n_out - b_out, 1);
    send_line("count=5\n");
    idle(3);
    chk("bp_next", last_out, 5);
  endtask

  task automatic test_reset_midline;
    int b_out;
    int b_err = n_err;
    send_line("count=1");
    reset_n = 1'b0;
    #2;
    total++;
    if ({out_valid, out_data, err, err_code, in_ready}
        !== {1'b0, 8'd0, 1'b0, 2'd0, 1'b1})
      $display("FAIL midrst_outputs got %b%h%b%h%b",
               out_valid, out_data, err, err_code,
               in_ready);
    else
      passed++;
    idle(1);
    reset_n = 1'b1;
    idle(1);
    send_line("count=3\n");
    idle(3);
    chk("midrst_data", last_out, 3);
    chk("midrst_noerr", n_err - b_err, 0);
    out_ready = 1'b0;
    send_line("count=8\n");
    chk("emitrst_valid", int'(out_valid), 1);
    reset_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0)
      $display("FAIL emitrst_drop got v=%b d=%0d",
               out_valid, out_data);
    else
      passed++;
    idle(1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    b_out = n_out;
    idle(3);
    chk("emitrst_noout", n_out - b_out, 0);
  endtask

  task automatic test_leading_zeros;
    int b_bytes = nbytes;
    int b_out = n_out;
    int b_err = n_err;
    send_line("count=0012\n");
    idle(3);
    chk("lz_nerr", n_err - b_err, 1);
    chk("lz_code", int'(last_code), 3);
    chk("lz_at", err_at - b_bytes, 10);
    chk("lz_noout", n_out - b_out, 0);
    send_line("count=012\n");
    idle(3);
    chk("lz_three", last_out, 12);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_prefix;
    test_cr_and_nl_prefix;
    test_backpressure;
    test_reset_midline;
    test_leading_zeros;
    chk("err_and_valid", n_both, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
